// File: rtl/ifetch_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
package ifetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int ILEN_DEFAULT = 32;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN_DEFAULT-1:0] inst;
        logic                    fault;
    } fetch_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with push/pop/clear, occupancy count and registered head storage.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: state updates use <= so every register here samples pre-edge values.
    // NOTE: storage is cleared on reset as well, so the head reads 0 rather than X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: credit-limited imem requests, PC/response pairing,
// backpressure buffering and single-cycle flush with in-flight response dropping.
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ILEN  = ILEN_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            imem_err_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] inst_o,
    output logic            fault_o
);
    logic [CW-1:0] inflight, inflight_nxt;
    logic [CW-1:0] drop, drop_nxt;
    logic [CW-1:0] pc_count, res_count;
    logic [CW:0]   occupancy;
    logic          pc_full, pc_empty, res_full, res_empty;
    logic          slot_free, issue, pop, res_push;
    logic [ILEN:0] res_head;

    assign pop       = valid_o & ready_i;
    // Counting the same-cycle pop lets a drained slot be reissued without a bubble.
    assign occupancy = {1'b0, inflight} + {1'b0, res_count} - {{CW{1'b0}}, pop};
    assign slot_free = occupancy < (CW+1)'(DEPTH);

    assign imem_req_o  = valid_i & slot_free & ~flush_i;
    assign imem_addr_o = pc_i;
    assign ready_o     = slot_free & imem_gnt_i & ~flush_i;
    assign issue       = valid_i & ready_o;
    assign res_push    = imem_rvalid_i & (drop == '0) & ~flush_i;

    assign valid_o = ~res_empty & ~flush_i;
    assign inst_o  = res_head[ILEN:1];
    assign fault_o = res_head[0];

    fifo_sync #(.WIDTH(XLEN), .DEPTH(DEPTH), .CW(CW)) u_pc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (pop),
        .clear (flush_i),
        .din   (pc_i),
        .dout  (pc_o),
        .count (pc_count),
        .full  (pc_full),
        .empty (pc_empty)
    );

    fifo_sync #(.WIDTH(ILEN + 1), .DEPTH(DEPTH), .CW(CW)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_push),
        .pop   (pop),
        .clear (flush_i),
        .din   ({imem_rdata_i, imem_err_i}),
        .dout  (res_head),
        .count (res_count),
        .full  (res_full),
        .empty (res_empty)
    );

    always_comb begin
        // NOTE: defaults first, so no branch leaves a value unassigned and no latch appears.
        inflight_nxt = inflight;
        drop_nxt     = drop;
        case ({issue, imem_rvalid_i})
            2'b10:   inflight_nxt = inflight + CW'(1);
            2'b01:   inflight_nxt = inflight - CW'(1);
            default: ;
        endcase
        // Every request still outstanding at a flush is stale, including those already being dropped.
        if (flush_i)                            drop_nxt = inflight - CW'(imem_rvalid_i);
        else if (imem_rvalid_i && drop != '0)   drop_nxt = drop - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_nxt;
            drop     <= drop_nxt;
        end
    end

    a_inflight_max:  assert property (@(posedge clk) disable iff (rst) inflight <= CW'(DEPTH));
    a_res_max:       assert property (@(posedge clk) disable iff (rst) res_count <= CW'(DEPTH));
    a_pc_pairing:    assert property (@(posedge clk) disable iff (rst)
        {1'b0, pc_count} == {1'b0, inflight} + {1'b0, res_count} - {1'b0, drop});
    a_rvalid_owed:   assert property (@(posedge clk) disable iff (rst) imem_rvalid_i |-> inflight != '0);
    a_res_no_ovf:    assert property (@(posedge clk) disable iff (rst) !(res_push && res_full && !pop));
    a_pc_no_ovf:     assert property (@(posedge clk) disable iff (rst) !(issue && pc_full && !pop));
    a_pc_no_udf:     assert property (@(posedge clk) disable iff (rst) pop |-> !pc_empty);
    a_valid_stable:  assert property (@(posedge clk) disable iff (rst)
        (valid_o && !ready_i) |=> (valid_o || flush_i));

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: in-order memory model plus a queue-level reference.
module tb_ifetch_stage;
    import ifetch_pkg::*;

    localparam int XLEN  = XLEN_DEFAULT;
    localparam int ILEN  = ILEN_DEFAULT;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk, rst;
    logic            valid_i, ready_o, flush_i, ready_i;
    logic [XLEN-1:0] pc_i, imem_addr_o, pc_o;
    logic            imem_req_o, imem_gnt_i, imem_rvalid_i, imem_err_i;
    logic [ILEN-1:0] imem_rdata_i, inst_o;
    logic            valid_o, fault_o;

    ifetch_stage #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .CW(CW)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .fault_o       (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A request accepted by memory; live=0 once a flush has made it stale.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
        bit          err;
    } mreq_t;

    mreq_t        mq[$];
    fetch_entry_t oq[$];
    logic [31:0]  seen_pc[$];
    bit           seen_fault[$];
    int           seen_cyc[$];

    int checks, errors, cyc, lat, stall_pct, err_pct, grants;
    logic [31:0] err_pc;
    bit last_issue, last_ready, last_req;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    function automatic int dead_cnt();
        int n = 0;
        foreach (mq[i]) if (!mq[i].live) n++;
        return n;
    endfunction

    task automatic clear_seen();
        seen_pc.delete();
        seen_fault.delete();
        seen_cyc.delete();
        grants = 0;
    endtask

    // One clock: drive memory response, compare against the reference, advance the models.
    task automatic tick();
        bit rv, exp_valid, pop_m, exp_slot, exp_req, exp_ready, acc;
        logic [31:0] acc_addr;
        mreq_t f;
        rv = (mq.size() > 0) && (mq[0].due <= cyc) && (int'($urandom_range(99)) >= stall_pct);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? inst_of(mq[0].addr) : $urandom();
        imem_err_i    = rv ? mq[0].err : 1'($urandom_range(1));
        #1;
        exp_valid = (oq.size() > 0) && !flush_i;
        pop_m     = exp_valid && ready_i;
        exp_slot  = (mq.size() + oq.size() - int'(pop_m)) < DEPTH;
        exp_req   = valid_i && exp_slot && !flush_i;
        exp_ready = exp_slot && imem_gnt_i && !flush_i;

        checks++;
        if (valid_o !== exp_valid) begin
            errors++;
            $display("FAIL valid_o cyc=%0d got=%b exp=%b", cyc, valid_o, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if ({pc_o, inst_o, fault_o} !== {oq[0].pc, oq[0].inst, oq[0].fault}) begin
                errors++;
                $display("FAIL head cyc=%0d got pc=%h inst=%h f=%b exp pc=%h inst=%h f=%b",
                         cyc, pc_o, inst_o, fault_o, oq[0].pc, oq[0].inst, oq[0].fault);
            end
        end
        checks++;
        if (ready_o !== exp_ready) begin
            errors++;
            $display("FAIL ready_o cyc=%0d got=%b exp=%b", cyc, ready_o, exp_ready);
        end
        checks++;
        if (imem_req_o !== exp_req) begin
            errors++;
            $display("FAIL imem_req_o cyc=%0d got=%b exp=%b", cyc, imem_req_o, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr_o !== pc_i) begin
                errors++;
                $display("FAIL imem_addr_o cyc=%0d got=%h exp=%h", cyc, imem_addr_o, pc_i);
            end
        end
        checks++;
        if (u_dut.inflight !== CW'(mq.size()) || u_dut.drop !== CW'(dead_cnt())) begin
            errors++;
            $display("FAIL counters cyc=%0d got inflight=%0d drop=%0d exp inflight=%0d drop=%0d",
                     cyc, u_dut.inflight, u_dut.drop, mq.size(), dead_cnt());
        end

        last_issue = valid_i && exp_ready;
        last_ready = ready_o;
        last_req   = imem_req_o;
        acc        = imem_req_o && imem_gnt_i;
        acc_addr   = imem_addr_o;
        if (acc) grants++;
        if (valid_o && ready_i) begin
            seen_pc.push_back(pc_o);
            seen_fault.push_back(fault_o);
            seen_cyc.push_back(cyc);
        end

        @(posedge clk);
        if (flush_i) begin
            oq.delete();
            foreach (mq[i]) mq[i].live = 1'b0;
        end else if (pop_m) begin
            void'(oq.pop_front());
        end
        if (rv) begin
            f = mq.pop_front();
            if (f.live && !flush_i) oq.push_back('{pc: f.addr, inst: inst_of(f.addr), fault: f.err});
        end
        if (acc) mq.push_back('{addr: acc_addr, due: cyc + lat, live: 1'b1,
                                err: (acc_addr == err_pc) || (int'($urandom_range(99)) < err_pct)});
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; stall_pct = 0;
        for (n = 0; n < 60 && (mq.size() > 0 || oq.size() > 0); n++) tick();
        checks++;
        if (mq.size() > 0 || oq.size() > 0) begin
            errors++;
            $display("FAIL drain timeout got mq=%0d oq=%0d exp 0", mq.size(), oq.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({valid_o, pc_o, inst_o, fault_o, imem_req_o, ready_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b pc=%h inst=%h f=%b req=%b rdy=%b exp all 0",
                     valid_o, pc_o, inst_o, fault_o, imem_req_o, ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_streaming();
        int issued = 0, low = 0, start;
        clear_seen();
        lat = 1; ready_i = 1'b1; imem_gnt_i = 1'b1; valid_i = 1'b1; pc_i = 32'h0;
        start = cyc;
        for (int n = 0; n < 12 && issued < 4; n++) begin
            tick();
            if (!last_ready) low++;
            if (last_issue) begin issued++; pc_i += 4; end
        end
        valid_i = 1'b0;
        repeat (6) tick();
        checks++;
        if (low != 0 || issued != 4) begin
            errors++;
            $display("FAIL stream_issue got low=%0d issued=%0d exp low=0 issued=4", low, issued);
        end
        checks++;
        if (seen_pc.size() != 4) begin
            errors++;
            $display("FAIL stream_count got=%0d exp=4", seen_pc.size());
        end
        for (int i = 0; i < 4 && i < seen_pc.size(); i++) begin
            checks++;
            if (seen_pc[i] !== 32'(4 * i) || seen_cyc[i] != start + 2 + i) begin
                errors++;
                $display("FAIL stream_order i=%0d got pc=%h cyc=%0d exp pc=%h cyc=%0d",
                         i, seen_pc[i], seen_cyc[i], 4 * i, start + 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int g0;
        drain(); clear_seen();
        lat = 1; ready_i = 1'b0; valid_i = 1'b1; imem_gnt_i = 1'b1; pc_i = 32'h0;
        repeat (5) begin tick(); if (last_issue) pc_i += 4; end
        checks++;
        if (grants != 2 || last_ready || last_req) begin
            errors++;
            $display("FAIL bp_hold got grants=%0d rdy=%b req=%b exp 2/0/0", grants, last_ready, last_req);
        end
        g0 = grants;
        ready_i = 1'b1;
        repeat (6) begin tick(); if (last_issue) pc_i += 4; end
        valid_i = 1'b0;
        repeat (6) tick();
        checks++;
        if (grants <= g0 || seen_pc.size() != grants) begin
            errors++;
            $display("FAIL bp_resume got grants=%0d seen=%0d exp grants>%0d seen=grants", grants, seen_pc.size(), g0);
        end
        foreach (seen_pc[i]) begin
            checks++;
            if (seen_pc[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL bp_order i=%0d got=%h exp=%h", i, seen_pc[i], 4 * i);
            end
        end
    endtask

    task automatic test_stall();
        int highs = 0;
        drain(); clear_seen();
        lat = 1; ready_i = 1'b1; valid_i = 1'b1; pc_i = 32'h80; imem_gnt_i = 1'b0;
        repeat (3) begin tick(); if (last_ready) highs++; end
        checks++;
        if (highs != 0 || grants != 0) begin
            errors++;
            $display("FAIL stall got ready_highs=%0d grants=%0d exp 0/0", highs, grants);
        end
        imem_gnt_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (grants != 1 || seen_pc.size() != 1 || seen_pc[0] !== 32'h80) begin
            errors++;
            $display("FAIL stall_grant got grants=%0d seen=%0d exp one issue of 00000080", grants, seen_pc.size());
        end
    endtask

    task automatic test_flush_inflight();
        int n;
        drain(); clear_seen();
        lat = 3; ready_i = 1'b1; imem_gnt_i = 1'b1; valid_i = 1'b1;
        pc_i = 32'h100; tick();
        pc_i = 32'h104; tick();
        flush_i = 1'b1; pc_i = 32'h200; tick();
        flush_i = 1'b0;
        checks++;
        if (u_dut.drop !== CW'(2)) begin
            errors++;
            $display("FAIL flush_drop got=%0d exp=2", u_dut.drop);
        end
        for (n = 0; n < 10; n++) begin tick(); if (last_issue) break; end
        valid_i = 1'b0;
        repeat (8) tick();
        checks++;
        if (n == 10 || seen_pc.size() != 1 || seen_pc[0] !== 32'h200 || u_dut.drop !== '0) begin
            errors++;
            $display("FAIL flush_resume got n=%0d seen=%0d drop=%0d exp first pc 00000200, drop 0",
                     n, seen_pc.size(), u_dut.drop);
        end
    endtask

    task automatic test_flush_full();
        drain(); clear_seen();
        lat = 1; ready_i = 1'b0; imem_gnt_i = 1'b1; valid_i = 1'b1;
        pc_i = 32'h300; tick();
        pc_i = 32'h304; tick();
        valid_i = 1'b0; flush_i = 1'b1; tick();
        flush_i = 1'b0; ready_i = 1'b1;
        checks++;
        if (valid_o !== 1'b0 || u_dut.drop !== '0 || u_dut.inflight !== '0) begin
            errors++;
            $display("FAIL flush_full got v=%b drop=%0d inflight=%0d exp 0/0/0", valid_o, u_dut.drop, u_dut.inflight);
        end
        repeat (5) tick();
        checks++;
        if (seen_pc.size() != 0) begin
            errors++;
            $display("FAIL flush_stale got=%0d entries exp=0", seen_pc.size());
        end
    endtask

    task automatic test_fault();
        int issued = 0;
        drain(); clear_seen();
        err_pc = 32'h40; lat = 1; ready_i = 1'b1; imem_gnt_i = 1'b1; valid_i = 1'b1; pc_i = 32'h38;
        for (int n = 0; n < 12 && issued < 4; n++) begin
            tick();
            if (last_issue) begin issued++; pc_i += 4; end
        end
        valid_i = 1'b0;
        repeat (5) tick();
        checks++;
        if (seen_pc.size() != 4) begin
            errors++;
            $display("FAIL fault_count got=%0d exp=4", seen_pc.size());
        end
        for (int i = 0; i < 4 && i < seen_pc.size(); i++) begin
            checks++;
            if (seen_pc[i] !== 32'(32'h38 + 4 * i) || seen_fault[i] !== (i == 2)) begin
                errors++;
                $display("FAIL fault_flag i=%0d got pc=%h f=%b exp pc=%h f=%b",
                         i, seen_pc[i], seen_fault[i], 32'h38 + 4 * i, i == 2);
            end
        end
        err_pc = 32'hffff_ffff;
    endtask

    task automatic test_async_reset();
        drain(); clear_seen();
        lat = 2; ready_i = 1'b0; imem_gnt_i = 1'b1; valid_i = 1'b1; pc_i = 32'h500;
        repeat (4) begin tick(); if (last_issue) pc_i += 4; end
        valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid_o, pc_o, inst_o, fault_o, imem_req_o} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%b pc=%h inst=%h f=%b req=%b exp all 0",
                     valid_o, pc_o, inst_o, fault_o, imem_req_o);
        end
        imem_rvalid_i = 1'b0;
        mq.delete();
        oq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            drain(); clear_seen();
            lat = 1 + r; stall_pct = 15 * r; err_pct = 10;
            pc_i = 32'h1000 * (r + 1);
            for (int n = 0; n < 300; n++) begin
                valid_i    = int'($urandom_range(99)) < 75;
                ready_i    = int'($urandom_range(99)) < 65;
                imem_gnt_i = int'($urandom_range(99)) < 75;
                flush_i    = int'($urandom_range(99)) < 4;
                tick();
                if (flush_i) pc_i = {16'h0, 16'($urandom()) & 16'hfffc};
                else if (last_issue) pc_i += 4;
            end
            err_pct = 0;
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1; stall_pct = 0; err_pct = 0; grants = 0;
        err_pc = 32'hffff_ffff;
        rst = 1'b1; valid_i = 1'b0; pc_i = '0; flush_i = 1'b0; ready_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; imem_err_i = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush_inflight();
        test_flush_full();
        test_fault();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Parametrised instruction-fetch pipeline stage.
- Sits between the PC generator (upstream valid/ready) and decode (downstream valid/ready).
- Drives a request/grant/response instruction-memory port with arbitrary in-order latency, and keeps up to DEPTH requests in flight.
- Pairs each returning instruction with its PC, buffers results under downstream backpressure, and supports a single-cycle flush that discards all in-flight and buffered fetches.

Parameters:
- XLEN, 32, width of PC and instruction-memory address.
- ILEN, 32, instruction word width.
- DEPTH, 2, max outstanding-plus-buffered fetches (power of two, >= 1).
- CW, $clog2(DEPTH+1), width of the occupancy and drop counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  upstream PC valid.
- ready_o  out  1  stage accepts pc_i this cycle.
- pc_i  in  XLEN  fetch address.
- flush_i  in  1  redirect: discard everything in flight and buffered.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  XLEN  request address (= pc_i).
- imem_gnt_i  in  1  request accepted by memory.
- imem_rvalid_i  in  1  response valid (in request order).
- imem_rdata_i  in  ILEN  response instruction.
- imem_err_i  in  1  response bus error, qualified by imem_rvalid_i.
- valid_o  out  1  fetched entry available to decode.
- ready_i  in  1  decode accepts entry.
- pc_o  out  XLEN  PC of head entry.
- inst_o  out  ILEN  instruction of head entry.
- fault_o  out  1  head entry carries bus error.

Behaviour:
- Reset: all counters 0, both FIFOs empty, drop counter 0; valid_o=0, pc_o=0, inst_o=0, fault_o=0, imem_req_o=0.
- State: inflight counter (granted, response not yet returned), pc FIFO (DEPTH x XLEN), result FIFO (DEPTH x {ILEN, 1}), drop counter.
- pop = valid_o & ready_i.
- Credit: slot_free = (inflight + res_count - pop) < DEPTH.
- imem_req_o = valid_i & slot_free & ~flush_i.
- ready_o = slot_free & imem_gnt_i & ~flush_i.
- Issue fires when valid_i & ready_o: pc_i is pushed to the pc FIFO and inflight increments.
- Response (imem_rvalid_i) with drop == 0: push {rdata, err} to the result FIFO; inflight decrements.
- Response with drop > 0: discard it, decrement drop, decrement inflight.
- Issue and response in the same cycle leave inflight unchanged.
- Output: valid_o = ~res_empty & ~flush_i. pc_o, inst_o and fault_o come from the FIFO heads (storage registers, no comb path from imem).
- pop pops both FIFOs.
- Latency: minimum pc_i to valid_o is 1 cycle plus memory latency. With 1-cycle memory latency and DEPTH >= 2, one fetch per cycle is sustained with no bubbles.
- Full: slot_free=0 gives ready_o=0 and imem_req_o=0. A same-cycle pop frees the slot combinationally.
- Empty: valid_o=0. A response never bypasses to the outputs in the cycle it arrives.
- Flush cycle:
  - Both FIFOs are cleared at the next edge; no issue and no pop happen.
  - drop <= inflight - (imem_rvalid_i ? 1 : 0); a response arriving in the flush cycle is discarded.
  - inflight keeps counting dropped requests, so credits stay exact.
- Issue may resume the cycle after a flush while drop > 0. New responses return only after all dropped ones (in-order memory), so pairing stays correct.
- Flush while drop > 0: drop recomputes from inflight as above (no accumulation error).
- imem_gnt_i without imem_req_o is ignored.
- An imem_rvalid_i with inflight == 0 is a protocol violation: assertion only.
- Reset mid-operation returns to reset state immediately. Responses to pre-reset requests are the memory's responsibility (memory resets on the same rst).
- Assertions:
  - inflight <= DEPTH.
  - res_count <= DEPTH.
  - pc_count == inflight + res_count - drop.
  - valid_o stable until pop, except on flush.

Decomposition:
- Package ifetch_pkg: typedef fetch_entry_t {pc, inst, fault} and the XLEN/ILEN defaults.
- One sub-module, fifo_sync (params WIDTH, DEPTH): synchronous FIFO with push, pop, clear, count, full/empty, asynchronous reset zeroing storage.
- ifetch_stage instantiates two fifo_sync (pc and result) plus the inflight/drop counters and handshake logic.

Test Plan:
- Streaming: DEPTH=2, 1-cycle memory latency, ready_i=1, PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles -> valid_o for 4 consecutive cycles, pc_o/inst_o paired in order, ready_o never low.
- Backpressure: ready_i=0 for 5 cycles while valid_i=1 -> exactly 2 requests granted, then ready_o=0 and imem_req_o=0. Release ready_i -> entries 0x0, 0x4 delivered first, then issue resumes.
- Stall: imem_gnt_i=0 for 3 cycles -> ready_o=0, pc_i held. Grant on the 4th cycle -> exactly one issue, correct pairing.
- Flush with in-flight: 3-cycle memory latency, issue 0x100 and 0x104, then flush_i, then issue 0x200 -> the 0x100/0x104 responses are discarded, first valid_o shows pc_o=0x200 with its data, drop returns to 0.
- Flush coincident with rvalid and a full result FIFO -> valid_o=0 the next cycle, drop = inflight-1, no stale entry ever appears.
- Fault: imem_err_i=1 on the 0x40 response -> fault_o=1 only for the pc_o=0x40 entry. Async reset mid-stream -> all outputs 0 within the same cycle.
